// File: rtl/compress_seq_pkg.sv
// Shared types and constants for the compression-pass sequencer:
// state encoding, CTRL/STAT register bit positions and the default pass length.
package compress_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int NPIX_DEFAULT = 784;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_ABORT_BIT  = 3;
  localparam int CTRL_IRQ_EN_BIT = 4;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;
  localparam int STAT_PIX_LSB  = 16;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Loadable up-counter with synchronous clear, count enable and a terminal-count flag.
module seq_timeout_cnt
  import compress_seq_pkg::*;
#(
  parameter int               WIDTH    = 21,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/compress_seq.sv
// Memory-mapped sequencer for the image compression pass: arms, starts and polices
// the compressor, gates image_mem writes. Optional irq support under COMPRESS_SEQ_IRQ_EN.
module compress_seq
  import compress_seq_pkg::*;
#(
  parameter int          NPIX      = NPIX_DEFAULT,
  parameter int          TIMEOUT   = 2000000,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_C008,
  parameter logic [31:0] STAT_ADDR = 32'h0000_C009
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        key_req,
  input  logic        frame_start,
  output logic        cmp_start,
  input  logic        cmp_wr,
  input  logic [9:0]  cmp_waddr,
  output logic        mem_we,
  output logic        busy,
  output logic        irq
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [9:0]    PIX_LAST   = 10'(NPIX - 1);

  state_t        state, next_state;
  logic          key_d, done, err;
  logic [9:0]    pix_cnt;
  logic [TW-1:0] timer;
  logic          timer_tc;
  logic          ctrl_wr, key_rise, start_req, clear_req, abort_req;
  logic          addr_ok, start_ok, enter_done, enter_err;
  logic          ctrl_irq_en;
  logic [31:0]   ctrl_word, stat_word;
  logic          unused_ok;

  assign ctrl_wr    = we && (addr == CTRL_ADDR);
  assign key_rise   = key_req && !key_d;
  assign start_req  = (ctrl_wr && wdata[CTRL_START_BIT]) || key_rise;
  assign clear_req  = ctrl_wr && wdata[CTRL_CLEAR_BIT];
  assign abort_req  = ctrl_wr && wdata[CTRL_ABORT_BIT];
  assign addr_ok    = (cmp_waddr == pix_cnt);
  assign start_ok   = !busy && start_req;
  assign enter_done = (state == RUN) && (next_state == DONE);
  assign enter_err  = busy && (next_state == ERR);

  seq_timeout_cnt #(
    .WIDTH    (TW),
    .TERMINAL (TIMER_LAST)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .load     (1'b0),
    .load_val ('0),
    .en       (busy),
    .count    (timer),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Abort beats timeout, and timeout beats both address errors and completion.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE, ERR: if (start_req) next_state = ARM;
      ARM: begin
        if (abort_req)        next_state = IDLE;
        else if (timer_tc)    next_state = ERR;
        else if (frame_start) next_state = RUN;
      end
      RUN: begin
        if (abort_req)                  next_state = IDLE;
        else if (timer_tc)              next_state = ERR;
        else if (cmp_wr && !addr_ok)    next_state = ERR;
        else if (cmp_wr && pix_cnt == PIX_LAST) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ARM) || (state == RUN);
    mem_we = (state == RUN) && cmp_wr && addr_ok && !abort_req && !timer_tc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_d     <= 1'b0;
      cmp_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pix_cnt   <= '0;
    end else begin
      key_d     <= key_req;
      cmp_start <= (state == ARM) && (next_state == RUN);
      if (start_ok) begin
        done    <= 1'b0;
        err     <= 1'b0;
        pix_cnt <= '0;
      end else if (!busy && clear_req) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (mem_we)     pix_cnt <= pix_cnt + 10'd1;
        if (enter_done) done    <= 1'b1;
        if (enter_err)  err     <= 1'b1;
      end
    end
  end

`ifdef COMPRESS_SEQ_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wdata[CTRL_IRQ_EN_BIT];
      if (!busy && (start_req || clear_req))       irq <= 1'b0;
      else if ((enter_done || enter_err) && irq_en) irq <= 1'b1;
    end
  end

  assign ctrl_irq_en = irq_en;
  assign unused_ok   = ^{wdata[31:5], wdata[2], timer};
`else
  assign irq         = 1'b0;
  assign ctrl_irq_en = 1'b0;
  assign unused_ok   = ^{wdata[31:4], wdata[2], timer};
`endif

  always_comb begin
    ctrl_word                               = '0;
    ctrl_word[CTRL_IRQ_EN_BIT]              = ctrl_irq_en;
    stat_word                               = '0;
    stat_word[STAT_BUSY_BIT]                = busy;
    stat_word[STAT_DONE_BIT]                = done;
    stat_word[STAT_ERR_BIT]                 = err;
    stat_word[STAT_PIX_LSB +: 10]           = pix_cnt;
    rdata = '0;
    if (re && addr == CTRL_ADDR)      rdata = ctrl_word;
    else if (re && addr == STAT_ADDR) rdata = stat_word;
  end

endmodule

// File: tb/tb_compress_seq.sv
// Scoreboard bench for compress_seq: directed stimulus pushes expectations, a negedge monitor
// compares register reads and the {irq, busy, mem_we, cmp_start} probe vector.
module tb_compress_seq;

  localparam logic [31:0] CTRL = 32'h0000_C008;
  localparam logic [31:0] STAT = 32'h0000_C009;
  localparam int          TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst, we, re, key_req, frame_start, cmp_wr, probe;
  logic [31:0] addr, wdata, rdata;
  logic [9:0]  cmp_waddr;
  logic        cmp_start, mem_we, busy, irq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   cs_cnt = 0;
  int   arm_cnt = 0;
  logic busy_prev = 1'b0;

  compress_seq #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .we          (we),
    .re          (re),
    .wdata       (wdata),
    .rdata       (rdata),
    .key_req     (key_req),
    .frame_start (frame_start),
    .cmp_start   (cmp_start),
    .cmp_wr      (cmp_wr),
    .cmp_waddr   (cmp_waddr),
    .mem_we      (mem_we),
    .busy        (busy),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_cnt++;
    if (cmp_start) cs_cnt++;
    if (busy && !busy_prev) arm_cnt++;
    busy_prev = busy;
    if (re || probe) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual=%h required=none", rdata);
      end else begin
        e = sbq.pop_front();
        checkOutput(e.name, re ? rdata : {28'b0, irq, busy, mem_we, cmp_start}, e.exp);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
    addr = a; we = w; re = r; wdata = d;
    tick();
    addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
  endtask

  task automatic ctrlWrite(input logic [31:0] d);
    applyStimulus(CTRL, 1'b1, 1'b0, d);
  endtask

  task automatic readReg(input logic [31:0] a, input string name, input logic [31:0] exp);
    sbq.push_back('{name, exp});
    applyStimulus(a, 1'b0, 1'b1, '0);
  endtask

  task automatic expectNext(input string name, input logic [31:0] exp);
    sbq.push_back('{name, exp});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic writePixels(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cmp_wr = 1'b1;
      cmp_waddr = 10'(i);
      tick();
    end
    cmp_wr = 1'b0;
  endtask

  task automatic frameGo();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    int arm_base;
    logic [31:0] irq_exp, irq_en_exp;
`ifdef COMPRESS_SEQ_IRQ_EN
    irq_exp = 32'h8;
    irq_en_exp = 32'h10;
`else
    irq_exp = 32'h0;
    irq_en_exp = 32'h0;
`endif
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; key_req = 1'b0;
    frame_start = 1'b0; cmp_wr = 1'b0; cmp_waddr = '0; probe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    readReg(STAT, "reset_stat", 32'h0);
    readReg(CTRL, "reset_ctrl", 32'h0);
    expectNext("reset_sigs", 32'h0);

    // Full in-order pass.
    ctrlWrite(32'h1);
    expectNext("arm_busy", 32'h4);
    readReg(STAT, "arm_stat", 32'h1);
    frameGo();
    expectNext("cmp_start_pulse", 32'h5);
    cmp_wr = 1'b1; cmp_waddr = 10'd0;
    expectNext("first_write", 32'h6);
    writePixels(1, 783);
    expectNext("done_sigs", 32'h0);
    readReg(STAT, "done_stat", 32'h0310_0002);
    checkOutput("pass_mem_we_count", we_cnt, 784);
    we_cnt = 0;

    // Out-of-order write mid-pass.
    ctrlWrite(32'h1);
    frameGo();
    tick();
    writePixels(0, 3);
    cmp_wr = 1'b1; cmp_waddr = 10'd5;
    expectNext("bad_write", 32'h4);
    cmp_wr = 1'b0;
    expectNext("err_sigs", 32'h0);
    readReg(STAT, "err_stat", 32'h0004_0004);
    checkOutput("err_mem_we_count", we_cnt, 4);

    // Timeout in ARM, then clear.
    ctrlWrite(32'h1);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", n, TMO);
    readReg(STAT, "timeout_stat", 32'h4);
    ctrlWrite(32'h2);
    readReg(STAT, "cleared_stat", 32'h0);

    // Start ignored in RUN, then abort alongside a write.
    we_cnt = 0;
    ctrlWrite(32'h1);
    frameGo();
    tick();
    writePixels(0, 149);
    cmp_wr = 1'b1; cmp_waddr = 10'd150;
    ctrlWrite(32'h1);
    writePixels(151, 299);
    cmp_wr = 1'b1; cmp_waddr = 10'd300;
    sbq.push_back('{"abort_write", 32'h4});
    probe = 1'b1;
    ctrlWrite(32'h8);
    probe = 1'b0;
    cmp_wr = 1'b0;
    expectNext("abort_sigs", 32'h0);
    readReg(STAT, "abort_stat", 32'h012C_0000);
    checkOutput("abort_mem_we_count", we_cnt, 300);

    // Held key gives one start; a second edge while busy does not restart.
    arm_base = arm_cnt;
    key_req = 1'b1;
    tick();
    n = 0;
    while (busy && n < 3000) begin
      if (n == 49) key_req = 1'b0;
      if (n == 59) key_req = 1'b1;
      tick();
      n++;
    end
    checkOutput("key_busy_cycles", n, TMO);
    checkOutput("key_arm_entries", arm_cnt - arm_base, 1);
    readReg(STAT, "key_stat", 32'h4);
    key_req = 1'b0;
    ctrlWrite(32'h2);

    // Reset mid-arm alongside frame_start: no cmp_start pulse.
    ctrlWrite(32'h1);
    frame_start = 1'b1; rst = 1'b1;
    tick();
    frame_start = 1'b0; rst = 1'b0;
    expectNext("midrst_sigs", 32'h0);
    readReg(STAT, "midrst_stat", 32'h0);

    // Interrupt on completion.
    ctrlWrite(32'h11);
    readReg(CTRL, "ctrl_irq_en", irq_en_exp);
    frameGo();
    tick();
    writePixels(0, 783);
    expectNext("irq_done", irq_exp);
    readReg(STAT, "irq_stat", 32'h0310_0002);
    ctrlWrite(32'h2);
    expectNext("irq_cleared", 32'h0);
    readReg(CTRL, "ctrl_after_clear", 32'h0);

    checkOutput("cmp_start_count", cs_cnt, 4);
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
